// File: rtl/set_controller.sv
// Clock-setting controller: debounced mode/up/down buttons drive
// the field-select FSM, auto-repeat strobes, idle exit and blink.
module debounce_stage #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press,
  output logic held
);
  localparam int DW =
    (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [DW-1:0] cnt;
  logic          level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      held  <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
      // held is the delayed level, so it rises with press
      held  <= level;
      press <= level & ~held;
    end
  end
endmodule

module set_controller #(
  parameter int DB_CYCLES     = 4,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 64,
  parameter int BLINK_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_mode,
  input  logic btn_up,
  input  logic btn_down,
  output logic set_hour,
  output logic set_min,
  output logic set_sec,
  output logic up,
  output logic down,
  output logic blink
);
  localparam logic [1:0] NORMAL   = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;
  localparam logic [1:0] SET_SEC  = 2'd3;

  localparam int RMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW =
    (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int IW =
    (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int BW =
    (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic pm, pu, pd;
  logic hm, hu, hd;

  debounce_stage #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw(btn_mode),
    .press(pm), .held(hm)
  );
  debounce_stage #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .raw(btn_up),
    .press(pu), .held(hu)
  );
  debounce_stage #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .raw(btn_down),
    .press(pd), .held(hd)
  );

  logic [1:0]    state, state_n;
  logic          act_up, act_up_n;
  logic          act_dn, act_dn_n;
  logic [RW-1:0] rep_cnt, rep_n, rep_lim;
  logic          rep_ph, ph_n;
  logic [IW-1:0] idle, idle_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          blink_n;
  logic          fire_up, fire_dn;
  logic          in_set, both, go_idle;
  logic          new_up, new_dn, rpt_up, rpt_dn;

  always_comb begin
    in_set  = (state != NORMAL);
    both    = hu & hd;
    go_idle = !in_set || pm || both;
    new_up  = !go_idle && pu;
    new_dn  = !go_idle && pd && !pu;
    rpt_up  = !go_idle && !pu && !pd
              && act_up && hu;
    rpt_dn  = !go_idle && !pu && !pd
              && act_dn && hd && !act_up;
    rep_lim = rep_ph ? RW'(REPEAT_CYCLES - 1)
                     : RW'(HOLD_CYCLES - 1);

    state_n  = state;
    fire_up  = 1'b0;
    fire_dn  = 1'b0;
    act_up_n = 1'b0;
    act_dn_n = 1'b0;
    rep_n    = '0;
    ph_n     = 1'b0;
    idle_n   = '0;
    blink_n  = blink;
    bcnt_n   = bcnt;

    unique case (1'b1)
      go_idle: ;
      new_up: begin
        fire_up  = 1'b1;
        act_up_n = 1'b1;
      end
      new_dn: begin
        fire_dn  = 1'b1;
        act_dn_n = 1'b1;
      end
      rpt_up: begin
        act_up_n = 1'b1;
        ph_n     = rep_ph;
        if (rep_cnt == rep_lim) begin
          fire_up = 1'b1;
          ph_n    = 1'b1;
        end else begin
          rep_n = rep_cnt + RW'(1);
        end
      end
      rpt_dn: begin
        act_dn_n = 1'b1;
        ph_n     = rep_ph;
        if (rep_cnt == rep_lim) begin
          fire_dn = 1'b1;
          ph_n    = 1'b1;
        end else begin
          rep_n = rep_cnt + RW'(1);
        end
      end
      default: ;
    endcase

    if (pm) begin
      case (state)
        NORMAL:   state_n = SET_HOUR;
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        default:  state_n = NORMAL;
      endcase
    end else if (in_set && !(pu | pd | hu | hd)) begin
      if (idle == IW'(IDLE_TIMEOUT - 1))
        state_n = NORMAL;
      else
        idle_n = idle + IW'(1);
    end

    if (state_n == NORMAL) begin
      blink_n = 1'b0;
      bcnt_n  = '0;
    end else if (state_n != state || fire_up || fire_dn) begin
      blink_n = 1'b1;
      bcnt_n  = '0;
    end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
      blink_n = ~blink;
      bcnt_n  = '0;
    end else begin
      bcnt_n = bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORMAL;
      act_up   <= 1'b0;
      act_dn   <= 1'b0;
      rep_cnt  <= '0;
      rep_ph   <= 1'b0;
      idle     <= '0;
      bcnt     <= '0;
      blink    <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      set_hour <= 1'b0;
      set_min  <= 1'b0;
      set_sec  <= 1'b0;
    end else begin
      state    <= state_n;
      act_up   <= act_up_n;
      act_dn   <= act_dn_n;
      rep_cnt  <= rep_n;
      rep_ph   <= ph_n;
      idle     <= idle_n;
      bcnt     <= bcnt_n;
      blink    <= blink_n;
      up       <= fire_up;
      down     <= fire_dn;
      set_hour <= (state_n == SET_HOUR);
      set_min  <= (state_n == SET_MIN);
      set_sec  <= (state_n == SET_SEC);
    end
  end

  logic unused_hm;
  assign unused_hm = hm;
endmodule

// File: tb/tb_set_controller.sv
// Scoreboard bench for set_controller: expected set vectors and
// strobe cycles are queued at stimulus time and popped on output.
module tb_set_controller;
  logic clk = 1'b0;
  logic rst_n;
  logic btn_mode, btn_up, btn_down;
  logic set_hour, set_min, set_sec;
  logic up, down, blink;

  set_controller dut (
    .clk(clk), .rst_n(rst_n),
    .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down),
    .set_hour(set_hour), .set_min(set_min),
    .set_sec(set_sec),
    .up(up), .down(down), .blink(blink)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int exp_q[$];
  logic [2:0] set_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic logic [2:0] sv();
    return {set_hour, set_min, set_sec};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic int rel();
    return cyc - base - 1;
  endfunction

  task automatic press_mode(input string tag,
                            input logic [2:0] prev,
                            input logic [2:0] nxt);
    set_q.push_back(nxt);
    base = cyc;
    for (int i = 0; i < 24; i++) begin
      btn_mode = (i < 12);
      step();
      if (rel() == 6)
        check({tag, "_pre"}, sv(), prev);
      if (rel() == 7) begin
        check(tag, sv(), set_q.pop_front());
        check({tag, "_blink"}, blink, nxt != 3'b000);
      end
      if (up | down)
        check({tag, "_strobe"}, {up, down}, 0);
    end
  endtask

  task automatic pop_pulse(input string tag, input int r);
    if (exp_q.size() > 0)
      check(tag, r, exp_q.pop_front());
    else
      check(tag, r, -1);
  endtask

  initial begin
    int r, n, last_t, toggles;
    logic last_b;
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    step();
    check("reset_outs",
          {set_hour, set_min, set_sec, up, down, blink}, 0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("reset_idle", sv(), 0);

    press_mode("mode_hour", 3'b000, 3'b100);
    press_mode("mode_min", 3'b100, 3'b010);
    press_mode("mode_sec", 3'b010, 3'b001);
    press_mode("mode_norm", 3'b001, 3'b000);
    check("norm_blink", blink, 0);

    press_mode("mode_hour1", 3'b000, 3'b100);
    // bouncing phase gives no press; stable from cycle 8
    base = cyc;
    exp_q.push_back(15);
    for (int i = 0; i < 50; i++) begin
      btn_up = (i < 10) ? ((i / 2) % 2 == 0) : (i < 30);
      step();
      r = rel();
      if (up && r < 23) pop_pulse("bounce_up", r);
      if (down) check("bounce_dn", down, 0);
    end
    check("bounce_left", exp_q.size(), 0);

    base = cyc;
    n = 0;
    toggles = 0;
    last_t = -1;
    last_b = blink;
    for (int i = 0; i < 70; i++) begin
      btn_up = (i < 50);
      btn_down = (i < 30);
      step();
      r = rel();
      if (up | down) n++;
      if (blink !== last_b) begin
        if (last_t >= 0)
          check("blink_period", r - last_t, 16);
        last_t = r;
        toggles++;
        last_b = blink;
      end
    end
    check("both_pulses", n, 0);
    check("blink_toggles", toggles >= 3, 1);
    check("both_state", sv(), 3'b100);

    press_mode("mode_min2", 3'b100, 3'b010);
    base = cyc;
    exp_q.push_back(7);
    for (int k = 15; k < 40; k += 4) exp_q.push_back(k);
    for (int i = 0; i < 80; i++) begin
      btn_up = (i < 40);
      step();
      r = rel();
      if (up) begin
        check("hold_blink", blink, 1);
        if (r < 40) pop_pulse("hold_up", r);
        else if (r >= 48) check("hold_late", r, -1);
      end
      if (down) check("hold_dn", down, 0);
    end
    check("hold_left", exp_q.size(), 0);

    press_mode("mode_sec2", 3'b010, 3'b001);
    base = cyc;
    for (int i = 0; i < 80; i++) begin
      step();
      if (rel() == 40) check("idle_hold", sv(), 3'b001);
    end
    check("idle_exit", sv(), 0);
    check("idle_blink", blink, 0);

    base = cyc;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      btn_up = (i < 20);
      step();
      if (up | down) n++;
    end
    check("normal_pulses", n, 0);
    check("normal_state", sv(), 0);

    press_mode("mode_hour3", 3'b000, 3'b100);
    base = cyc;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      btn_up = 1'b1;
      step();
      if (up) n++;
    end
    check("pre_rst_pulses", n, 3);
    check("pre_rst_up", up, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async",
          {set_hour, set_min, set_sec, up, down, blink}, 0);
    step();
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (up | down) n++;
    end
    check("post_rst_pulses", n, 0);
    check("post_rst_set", sv(), 0);
    btn_up = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/set_controller.md
SET_CONTROLLER -- requirements
Module: set_controller

Interface
REQ-001 Parameter DB_CYCLES, default 4, consecutive stable synchronized cycles required before a debounced button level changes.
REQ-002 Parameter HOLD_CYCLES, default 8, cycles from the first up/down pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_CYCLES, default 4, cycles between successive auto-repeat pulses.
REQ-004 Parameter IDLE_TIMEOUT, default 64, cycles without a debounced press edge before a set state exits to NORMAL.
REQ-005 Parameter BLINK_CYCLES, default 16, cycles per blink half-period.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_mode / btn_up / btn_down  input  1 each  raw asynchronous push-buttons, high = pressed.
REQ-009 set_hour / set_min / set_sec  output  1 each  registered manual-set enables for the hour/minute/second counters; at most one high.
REQ-010 up / down  output  1 each  registered single-cycle increment/decrement strobes to the counter selected by set_*.
REQ-011 blink  output  1  display blink enable for the selected field.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose level changes only after DB_CYCLES consecutive equal synchronized samples.
REQ-013 A debounced rising edge SHALL count as a press; falling edges produce no action.
REQ-014 FSM states SHALL be NORMAL, SET_HOUR, SET_MIN, SET_SEC; a mode press advances NORMAL->SET_HOUR->SET_MIN->SET_SEC->NORMAL.
REQ-015 set_hour/set_min/set_sec SHALL be high exactly in SET_HOUR/SET_MIN/SET_SEC respectively; all low in NORMAL.
REQ-016 A raw press held stable from cycle 0 SHALL produce its action (state change or strobe) visible on outputs at cycle DB_CYCLES+3.
REQ-017 In a set state, an up (down) press SHALL produce one up (down) pulse of exactly one cycle.
REQ-018 While the debounced up (down) stays high, a repeat pulse SHALL occur HOLD_CYCLES after the first pulse, then every REPEAT_CYCLES, until release.
REQ-019 up and down SHALL never be high in the same cycle and SHALL never be high in NORMAL.
REQ-020 If debounced up and down are both high, no pulses SHALL be issued and the repeat timer SHALL clear; after one is released, the remaining button issues nothing until released and pressed again.
REQ-021 A mode press while up/down is held SHALL change state, stop repeats, and block that button until it is released and pressed again.
REQ-022 Up/down presses in NORMAL SHALL be ignored and SHALL NOT be remembered.
REQ-023 In a set state, IDLE_TIMEOUT cycles with no debounced press edge and no held up/down SHALL force NORMAL; any press edge restarts the timer.
REQ-024 blink SHALL be 1 on entry to a set state and toggle every BLINK_CYCLES cycles; every up/down pulse forces blink=1 and restarts its counter; blink=0 in NORMAL.
REQ-025 All counters SHALL saturate or clear, never wrap, and SHALL be sized by $clog2 of their parameter.

Reset
REQ-026 rst_n low SHALL immediately force state NORMAL; set_*, up, down, blink = 0; synchronizers, debounced levels and all counters = 0.
REQ-027 A button held high through reset release SHALL debounce to 1 and count as a new press.
REQ-028 Reset asserted mid-repeat or mid-timeout SHALL abort the operation with no further pulses.

Verification
REQ-029 Reset, clean mode press -> set_hour=1 at cycle 7; three more presses -> set_min, set_sec, then all set_*=0.
REQ-030 SET_HOUR, btn_up toggling every 2 cycles for 10 cycles, then high 20 cycles -> exactly one up pulse.
REQ-031 SET_MIN, btn_up held 40 cycles -> up pulses at cycles 7, 15, 19, 23, 27, 31, 35, 39, and none after release plus debounce.
REQ-032 SET_HOUR, btn_up and btn_down both held 30 cycles -> zero up/down pulses, blink toggling normally.
REQ-033 SET_SEC, no input for 64 cycles -> all set_*=0, blink=0; NORMAL with btn_up press -> no up pulse.
REQ-034 rst_n low during auto-repeat -> outputs 0 in the same cycle, asynchronously; release with btn_up held in NORMAL -> no up pulse.
